// File: rtl/fp_add_pipe_if.sv
// ---------------------------------------------------------------------------
// fp_add_pipe_if
//
// Handshake and data bundle for the pipelined floating-point adder.
//
// Signals (W = 1 + EXP_W + MAN_W):
//   in_valid  : operands valid                  (master -> slave)
//   in_ready  : adder can accept this cycle      (slave  -> master)
//   a, b      : operands {sign, exponent, frac}  (master -> slave)
//   sub       : 1 = a - b, 0 = a + b             (master -> slave)
//   out_valid : result valid                     (slave  -> master)
//   out_ready : downstream accepts the result    (master -> slave)
//   result    : rounded sum                      (slave  -> master)
//   ovf       : result overflowed to infinity    (slave  -> master)
//   inexact   : rounding discarded nonzero bits  (slave  -> master)
//
// Modports:
//   master : the side that issues operations and consumes results
//   slave  : the adder itself
// ---------------------------------------------------------------------------
interface fp_add_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         ovf;
    logic         inexact;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, ovf, inexact
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, ovf, inexact
    );
endinterface

// File: rtl/fp_add_pipe.sv
// ---------------------------------------------------------------------------
// fp_add_pipe
//
// Three-stage pipelined floating-point adder/subtractor with
// round-to-nearest-even, overflow/inexact flags and valid/ready
// back-pressure. One operation per cycle, latency 3 cycles.
//
//   Stage 1 : unpack, order operands by magnitude, align the smaller one
//   Stage 2 : significand add/subtract
//   Stage 3 : normalise, round, pack (registered outputs)
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : fp_add_pipe_if.slave (in_valid/in_ready/a/b/sub,
//          out_valid/out_ready/result/ovf/inexact)
//
// Parameters:
//   EXP_W : exponent width (4..11)
//   MAN_W : stored fraction width (4..52)
//
// Build option:
//   FP_ADD_SPECIALS_EN : when defined, an all-ones exponent is decoded as
//   Inf/NaN. NaN inputs and Inf-Inf give the canonical quiet NaN,
//   Inf +/- finite gives that Inf. When undefined, an all-ones exponent is
//   an ordinary finite exponent.
// ---------------------------------------------------------------------------
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic           clk,
    input  logic           rst,
    fp_add_pipe_if.slave   bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int FW = MAN_W + 4;   // hidden, fraction, guard, round, sticky
    localparam int SW = MAN_W + 5;   // FW plus adder carry
    localparam int CW = EXP_W + 8;   // exponent / shift arithmetic width

    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [31:0]      ALIGN_MAX = 32'(MAN_W + 4);

    // Leading-zero count of the pre-normalisation significand.
    function automatic logic [CW-1:0] lzc(input logic [FW-1:0] v);
        logic [CW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = FW - 1; i >= 0; i--) begin
            if (!found && !v[i]) n = n + CW'(1);
            else                 found = 1'b1;
        end
        return n;
    endfunction

    // -----------------------------------------------------------------------
    // Global stall: the output register holds an unaccepted result.
    // -----------------------------------------------------------------------
    logic w_stall;
    logic r_out_valid;

    assign w_stall      = r_out_valid & ~bus.out_ready;
    assign bus.in_ready = ~w_stall;

    // -----------------------------------------------------------------------
    // Stage 1: unpack and align
    // -----------------------------------------------------------------------
    logic             w_sign_a, w_sign_b;
    logic [EXP_W-1:0] w_exp_a, w_exp_b;
    logic [EXP_W-1:0] w_eexp_a, w_eexp_b;
    logic [MAN_W:0]   w_sig_a, w_sig_b;
    logic             w_a_ge_b;
    logic             w_sign_x;
    logic [EXP_W-1:0] w_exp_x, w_exp_y, w_exp_diff;
    logic [MAN_W:0]   w_sig_x, w_sig_y;
    logic [31:0]      w_shamt;
    logic [2*FW-1:0]  w_y_ext;
    logic [FW-1:0]    w_y_align;

    assign w_sign_a = bus.a[W-1];
    assign w_sign_b = bus.b[W-1] ^ bus.sub;
    assign w_exp_a  = bus.a[W-2:MAN_W];
    assign w_exp_b  = bus.b[W-2:MAN_W];
    // A zero exponent is a subnormal: exponent 1, hidden bit 0.
    assign w_eexp_a = (w_exp_a == '0) ? EXP_W'(1) : w_exp_a;
    assign w_eexp_b = (w_exp_b == '0) ? EXP_W'(1) : w_exp_b;
    assign w_sig_a  = {w_exp_a != '0, bus.a[MAN_W-1:0]};
    assign w_sig_b  = {w_exp_b != '0, bus.b[MAN_W-1:0]};
    // The packed exponent/fraction field orders magnitudes directly.
    assign w_a_ge_b = bus.a[W-2:0] >= bus.b[W-2:0];

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        w_sign_x = w_sign_a;
        w_exp_x  = w_eexp_a;
        w_exp_y  = w_eexp_b;
        w_sig_x  = w_sig_a;
        w_sig_y  = w_sig_b;
        if (!w_a_ge_b) begin
            w_sign_x = w_sign_b;
            w_exp_x  = w_eexp_b;
            w_exp_y  = w_eexp_a;
            w_sig_x  = w_sig_b;
            w_sig_y  = w_sig_a;
        end
        w_exp_diff = w_exp_x - w_exp_y;
        // Beyond MAN_W+4 everything lands in sticky anyway; clamping keeps
        // the shifter narrow and makes huge differences leave sticky=(Y!=0).
        w_shamt = {{(32-EXP_W){1'b0}}, w_exp_diff};
        if (w_shamt > ALIGN_MAX) w_shamt = ALIGN_MAX;
        // Lower half catches every bit shifted past the sticky position.
        w_y_ext   = {w_sig_y, 3'b000, {FW{1'b0}}} >> w_shamt;
        w_y_align = {w_y_ext[2*FW-1:FW+1], w_y_ext[FW] | (|w_y_ext[FW-1:0])};
    end

`ifdef FP_ADD_SPECIALS_EN
    logic w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    logic w_nan, w_inf, w_inf_sign;

    assign w_nan_a    = (w_exp_a == EXP_ONES) && (bus.a[MAN_W-1:0] != '0);
    assign w_nan_b    = (w_exp_b == EXP_ONES) && (bus.b[MAN_W-1:0] != '0);
    assign w_inf_a    = (w_exp_a == EXP_ONES) && (bus.a[MAN_W-1:0] == '0);
    assign w_inf_b    = (w_exp_b == EXP_ONES) && (bus.b[MAN_W-1:0] == '0);
    assign w_nan      = w_nan_a | w_nan_b | (w_inf_a & w_inf_b & (w_sign_a ^ w_sign_b));
    assign w_inf      = w_inf_a | w_inf_b;
    assign w_inf_sign = w_inf_a ? w_sign_a : w_sign_b;

    logic r1_nan, r1_inf, r1_inf_sign;
    logic r2_nan, r2_inf, r2_inf_sign;
`endif

    logic             r1_valid, r2_valid;
    logic             r1_sign, r1_eff_sub;
    logic [EXP_W-1:0] r1_exp;
    logic [FW-1:0]    r1_sig_x, r1_sig_y;

    // -----------------------------------------------------------------------
    // Stage 2: add / subtract (X >= Y, so the difference is never negative)
    // -----------------------------------------------------------------------
    logic [SW-1:0]    w_sum;
    logic             r2_sign, r2_eff_sub;
    logic [EXP_W-1:0] r2_exp;
    logic [SW-1:0]    r2_sum;

    assign w_sum = r1_eff_sub ? ({1'b0, r1_sig_x} - {1'b0, r1_sig_y})
                              : ({1'b0, r1_sig_x} + {1'b0, r1_sig_y});

    // NOTE: datapath registers carry no reset; the stage valid bits decide whether they matter.
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r1_sign     <= w_sign_x;
            r1_eff_sub  <= w_sign_a ^ w_sign_b;
            r1_exp      <= w_exp_x;
            r1_sig_x    <= {w_sig_x, 3'b000};
            r1_sig_y    <= w_y_align;
            r2_sign     <= r1_sign;
            r2_eff_sub  <= r1_eff_sub;
            r2_exp      <= r1_exp;
            r2_sum      <= w_sum;
`ifdef FP_ADD_SPECIALS_EN
            r1_nan      <= w_nan;
            r1_inf      <= w_inf;
            r1_inf_sign <= w_inf_sign;
            r2_nan      <= r1_nan;
            r2_inf      <= r1_inf;
            r2_inf_sign <= r1_inf_sign;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3: normalise, round, pack
    // -----------------------------------------------------------------------
    logic [CW-1:0]  w_exp_c, w_lz, w_max_sh, w_sh, w_exp_n, w_exp_f;
    logic [FW-1:0]  w_norm;
    logic [MAN_W+1:0] w_rnd;
    logic [MAN_W-1:0] w_frac_f;
    logic           w_round_up, w_zero;
    logic [W-1:0]   w_res;
    logic           w_ovf, w_inexact;

    always_comb begin
        w_exp_c  = CW'(r2_exp);
        w_lz     = lzc(r2_sum[FW-1:0]);
        w_max_sh = w_exp_c - CW'(1);
        w_sh     = '0;
        w_norm   = r2_sum[FW-1:0];
        w_exp_n  = w_exp_c;
        if (r2_sum[SW-1]) begin
            // Carry out: shift right once, folding the lost bit into sticky.
            w_norm  = {r2_sum[SW-1:2], r2_sum[1] | r2_sum[0]};
            w_exp_n = w_exp_c + CW'(1);
        end else begin
            // Stop at exponent 1; a result still lacking its hidden bit is subnormal.
            w_sh    = (w_lz < w_max_sh) ? w_lz : w_max_sh;
            w_norm  = r2_sum[FW-1:0] << w_sh;
            w_exp_n = w_exp_c - w_sh;
        end
        w_zero     = (r2_sum == '0);
        w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd      = {1'b0, w_norm[FW-1:3]} + (MAN_W+2)'(w_round_up);

        // Exponent follows the rounded hidden bit: rounding can carry into a
        // new binade, or lift a subnormal into the smallest normal.
        w_exp_f  = '0;
        w_frac_f = w_rnd[MAN_W-1:0];
        if (w_rnd[MAN_W+1]) begin
            w_exp_f  = w_exp_n + CW'(1);
            w_frac_f = '0;
        end else if (w_rnd[MAN_W]) begin
            w_exp_f  = w_exp_n;
        end

        w_ovf     = 1'b0;
        w_inexact = |w_norm[2:0];
        w_res     = {r2_sign, w_exp_f[EXP_W-1:0], w_frac_f};
        if (w_zero) begin
            // Cancellation is +0; only a genuine add of two zeros keeps X's sign.
            w_res     = {r2_sign & ~r2_eff_sub, {(W-1){1'b0}}};
            w_inexact = 1'b0;
        end else if (w_exp_f >= CW'(EXP_ONES)) begin
            w_res = {r2_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_ovf = 1'b1;
        end
`ifdef FP_ADD_SPECIALS_EN
        if (r2_nan) begin
            w_res     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            w_ovf     = 1'b0;
            w_inexact = 1'b0;
        end else if (r2_inf) begin
            w_res     = {r2_inf_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_ovf     = 1'b0;
            w_inexact = 1'b0;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Valid chain and output register
    // -----------------------------------------------------------------------
    logic [W-1:0] r_result;
    logic         r_ovf, r_inexact;

    // NOTE: sequential state uses non-blocking assignments so each stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid    <= 1'b0;
            r2_valid    <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_inexact   <= 1'b0;
        end else if (!w_stall) begin
            r1_valid    <= bus.in_valid;
            r2_valid    <= r1_valid;
            r_out_valid <= r2_valid;
            r_result    <= w_res;
            r_ovf       <= w_ovf;
            r_inexact   <= w_inexact;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.ovf       = r_ovf;
    assign bus.inexact   = r_inexact;

endmodule

// File: tb/tb_fp_add_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_add_pipe
//
// Directed bench for fp_add_pipe at default parameters (single precision).
// A table of hand-computed vectors is streamed through the pipe; a negedge
// monitor compares every output transfer against an in-order queue of the
// expected records. Hand-written sequences cover latency, back-pressure and
// reset with operations in flight.
// ---------------------------------------------------------------------------
module tb_fp_add_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         ovf;
        logic         inexact;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fp_add_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   cyc      = 0;
    vec_t vecs[$];
    vec_t exp_q[$];
    vec_t mv;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    // Output monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got result 0x%0h with no operation pending", bus.result);
            end else begin
                mv = exp_q.pop_front();
                check({mv.name, "_result"},  bus.result,       mv.res);
                check({mv.name, "_ovf"},     32'(bus.ovf),     32'(mv.ovf));
                check({mv.name, "_inexact"}, 32'(bus.inexact), 32'(mv.inexact));
            end
        end
    end

    // Called at posedge+1; offers one operation and returns at posedge+1
    // after the edge that accepted it.
    task automatic send(input vec_t v);
        int waited;
        bus.in_valid = 1'b1;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.sub      = v.sub;
        waited       = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_accept: in_ready held at 0 for %0d cycles", v.name, waited);
        end else begin
            exp_q.push_back(v);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t p[4];
        int   lat, start, n0, seen;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        vecs.push_back('{"one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0});
        vecs.push_back('{"cancel",         32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"tie_even_up",    32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b1});
        vecs.push_back('{"overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0});
        vecs.push_back('{"subnormal_add",  32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0});
        vecs.push_back('{"one_plus_two",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0});
        vecs.push_back('{"one_minus_two",  32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0});
        vecs.push_back('{"tie_even_down",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b1});
        vecs.push_back('{"above_half",     32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b1});
        vecs.push_back('{"negzero_sum",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0});
        vecs.push_back('{"mixed_zero_sum", 32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"subn_to_norm",   32'h007FFFFF, 32'h00000001, 1'b0, 32'h00800000, 1'b0, 1'b0});
        vecs.push_back('{"norm_to_subn",   32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 1'b0, 1'b0});
        vecs.push_back('{"round_renorm",   32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 1'b0, 1'b1});
        vecs.push_back('{"sticky_only",    32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 1'b0, 1'b1});
        vecs.push_back('{"neg_plus_pos",   32'hC0400000, 32'h3F800000, 1'b0, 32'hC0000000, 1'b0, 1'b0});
        vecs.push_back('{"neg_overflow",   32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF800000, 1'b1, 1'b0});
`ifdef FP_ADD_SPECIALS_EN
        vecs.push_back('{"inf_minus_inf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0});
        vecs.push_back('{"nan_in",         32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0});
        vecs.push_back('{"inf_plus_fin",   32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0});
`else
        vecs.push_back('{"inf_minus_inf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"nan_in",         32'h7F800001, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1, 1'b1});
        vecs.push_back('{"inf_plus_fin",   32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1, 1'b1});
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_result",    bus.result,         32'(0));
        check("rst_ovf",       32'(bus.ovf),       32'(0));
        check("rst_inexact",   32'(bus.inexact),   32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #1;

        // Latency: count rising edges from presenting the operands to out_valid.
        bus.in_valid = 1'b1;
        bus.a        = vecs[0].a;
        bus.b        = vecs[0].b;
        bus.sub      = vecs[0].sub;
        @(negedge clk);
        check("lat_in_ready", 32'(bus.in_ready), 32'(1));
        exp_q.push_back(vecs[0]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(3));
        @(posedge clk);
        #1;
        check("lat_out_valid_clears", 32'(bus.out_valid), 32'(0));

        // Table stream, back to back: one acceptance per cycle.
        start = cyc;
        foreach (vecs[i]) send(vecs[i]);
        check("throughput_cycles", 32'(cyc - start), 32'(vecs.size()));
        drain("table_drain");

        // Back-pressure: 4 operations, output held off for 5 cycles.
        for (int i = 0; i < 4; i++) p[i] = vecs[2 + i];
        n0 = n_out;
        send(p[0]);
        send(p[1]);
        bus.out_ready = 1'b0;
        send(p[2]);
        check("bp_out_valid_rise", 32'(bus.out_valid), 32'(1));
        check("bp_in_ready_drop",  32'(bus.in_ready),  32'(0));
        bus.in_valid = 1'b1;
        bus.a        = p[3].a;
        bus.b        = p[3].b;
        bus.sub      = p[3].sub;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid",    32'(bus.out_valid), 32'(1));
            check("bp_hold_in_ready", 32'(bus.in_ready),  32'(0));
            check("bp_hold_result",   bus.result,         p[0].res);
            check("bp_hold_ovf",      32'(bus.ovf),       32'(p[0].ovf));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'(1));
        exp_q.push_back(p[3]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain("bp_drain");
        check("bp_output_count", 32'(n_out - n0), 32'(4));

        // Reset with three operations in flight.
        bus.out_ready = 1'b0;
        send(vecs[6]);
        send(vecs[7]);
        send(vecs[8]);
        check("inflight_out_valid", 32'(bus.out_valid), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'(1));
        check("mid_rst_result",    bus.result,         32'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        seen          = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("rst_nothing_emitted", 32'(seen), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
